mem_op_controller: RTL

- Sequences data-memory transactions requested by the control unit's microcode (MFA/MOC handshake) onto the synchronous data RAM.
- Latches the request, performs byte/halfword/word lane steering for STR/STRB/LDR/LDRB, waits a fixed RAM latency and returns MOC plus read data.
- Sits between the datapath (MAR/MDR) and the RAM; the microstore's conditional next-state logic tests MOC.

---
 rtl/mem_op_pkg.sv | 18 +
 rtl/byte_lane_steer.sv | 41 ++++
 rtl/mem_op_controller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_op_pkg.sv
// mem_op_pkg: shared FSM encoding, transfer-size codes and direction constants.
package mem_op_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        ERROR  = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/byte_lane_steer.sv
// byte_lane_steer: big-endian lane steering between CPU-side data and the 32-bit RAM word.
//   size       - transfer size code (byte/half/word/reserved)
//   addr_lo    - byte offset within the word
//   wr_data    - store data, byte/halfword in the low bits
//   ram_rdata  - word read from RAM
//   ram_wdata  - store data replicated across lanes
//   byte_en    - lane enables for the addressed bytes
//   rd_data    - selected byte/halfword zero-extended
//   bad_req    - misaligned access or reserved size
module byte_lane_steer
    import mem_op_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] ram_rdata,
    output logic [31:0] ram_wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] rd_data,
    output logic        bad_req
);

    logic [31:0] byte_sh;

    always_comb begin
        // lane k sits at bits [31-8k:24-8k], so shift by 8*(3-k) to bring it to the bottom
        byte_sh   = ram_rdata >> {~addr_lo, 3'b000};
        ram_wdata = (size == SZ_BYTE) ? {4{wr_data[7:0]}} :
                    (size == SZ_HALF) ? {2{wr_data[15:0]}} : wr_data;
        byte_en   = (size == SZ_BYTE) ? (4'b1000 >> addr_lo) :
                    (size == SZ_HALF) ? (addr_lo[1] ? 4'b0011 : 4'b1100) :
                    (size == SZ_WORD) ? 4'b1111 : 4'b0000;
        rd_data   = (size == SZ_BYTE) ? {24'b0, byte_sh[7:0]} :
                    (size == SZ_HALF) ? {16'b0, addr_lo[1] ? ram_rdata[15:0] : ram_rdata[31:16]} :
                    ram_rdata;
        bad_req   = (size == 2'b11) ||
                    (size == SZ_HALF && addr_lo[0]) ||
                    (size == SZ_WORD && addr_lo != 2'b00);
    end

endmodule

// File: rtl/mem_op_controller.sv
// mem_op_controller: runs one MFA/MOC memory transaction against a fixed-latency synchronous RAM.
//   Clk, Reset_n        - clock and asynchronous active-low reset
//   MFA, RW, Size, Addr - request from microcode (latched in IDLE)
//   WrData              - store data from MDR
//   RdData              - zero-extended load result, held until the next completed read
//   MOC, Err            - completion and error handshake back to the control unit
//   Ram_*               - RAM enable, direction, word address, write data, lane enables, read data
module mem_op_controller
    import mem_op_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WrData,
    output logic [31:0]       RdData,
    output logic              MOC,
    output logic              Err,
    output logic              Ram_En,
    output logic              Ram_RW,
    output logic [ADDR_W-3:0] Ram_Addr,
    output logic [31:0]       Ram_WData,
    output logic [3:0]        Ram_ByteEn,
    input  logic [31:0]       Ram_RData
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rd_data_q, rd_data_d;

    logic [1:0]  st_size;
    logic [1:0]  st_addr_lo;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] st_rdata;
    logic        st_bad;
    logic        in_access;
    logic        wr_access;

    // In IDLE the steerer looks at the live request so the alignment check
    // decides the branch on the latching edge; afterwards it sees the latched copy.
    assign st_size    = (state_q == IDLE) ? Size : size_q;
    assign st_addr_lo = (state_q == IDLE) ? Addr[1:0] : addr_q[1:0];

    byte_lane_steer u_steer (
        .size      (st_size),
        .addr_lo   (st_addr_lo),
        .wr_data   (wdata_q),
        .ram_rdata (Ram_RData),
        .ram_wdata (st_wdata),
        .byte_en   (st_be),
        .rd_data   (st_rdata),
        .bad_req   (st_bad)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    rw_d    = RW;
                    size_d  = Size;
                    addr_d  = Addr;
                    wdata_d = WrData;
                    state_d = st_bad ? ERROR : ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (rw_q == RW_READ) rd_data_d = st_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (!MFA) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign in_access  = (state_q == ACCESS);
    assign wr_access  = in_access && (rw_q == RW_WRITE);
    assign Ram_En     = in_access;
    assign Ram_RW     = in_access && rw_q;
    assign Ram_Addr   = in_access ? addr_q[ADDR_W-1:2] : '0;
    assign Ram_WData  = wr_access ? st_wdata : 32'b0;
    assign Ram_ByteEn = wr_access ? st_be : 4'b0000;
    assign MOC        = (state_q == DONE) || (state_q == ERROR);
    assign Err        = (state_q == ERROR);
    assign RdData     = rd_data_q;

endmodule
